// File: rtl/onehot_seq_gen.sv
// Programmable one-hot sequencer with a run-time writable transition table and
// Moore output table. It steps forward, steps in reverse, or holds, and recovers from corrupted state.
module onehot_seq_gen #(
  parameter int NSTATES = 7,
  parameter int YW      = 2,
  parameter int IW      = $clog2(NSTATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [IW-1:0]      cfg_next,
  input  logic [YW-1:0]      cfg_y,
  output logic [NSTATES-1:0] state,
  output logic [IW-1:0]      state_idx,
  output logic [YW-1:0]      y,
  output logic               wrap,
  output logic               cfg_err,
  output logic               fault
);

  localparam logic [IW:0] NST = NSTATES[IW:0];

  logic [NSTATES-1:0] state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [YW-1:0]      y_q, y_d;
  logic               wrap_q, wrap_d;
  logic               cfg_err_q, cfg_err_d;
  logic               fault_q, fault_d;
  logic [IW-1:0]      nxt_q [NSTATES];
  logic [IW-1:0]      nxt_d [NSTATES];
  logic [YW-1:0]      ytab_q [NSTATES];
  logic [YW-1:0]      ytab_d [NSTATES];

  logic [NSTATES-1:0] oh_cur;
  logic               bad;
  logic               pred_found;
  logic [IW-1:0]      pred_idx;
  logic               do_step;
  logic [IW-1:0]      new_idx;

  assign oh_cur = {{(NSTATES-1){1'b0}}, 1'b1} << idx_q;
  // The index must be in range and agree with the one-hot vector; this also
  // catches an all-zero state paired with an out-of-range index.
  assign bad    = ({1'b0, idx_q} >= NST) || (state_q != oh_cur);

  // Reverse step target: the lowest entry whose successor is the current state.
  always_comb begin
    pred_found = 1'b0;
    pred_idx   = '0;
    for (int j = NSTATES - 1; j >= 0; j--) begin
      if (nxt_q[j] == idx_q) begin
        pred_found = 1'b1;
        pred_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    y_d       = y_q;
    wrap_d    = 1'b0;
    cfg_err_d = 1'b0;
    fault_d   = 1'b0;
    nxt_d     = nxt_q;
    ytab_d    = ytab_q;
    do_step   = 1'b0;
    new_idx   = '0;

    if (bad) begin
      state_d = {{(NSTATES-1){1'b0}}, 1'b1};
      idx_d   = '0;
      y_d     = ytab_q[0];
      fault_d = 1'b1;
    end else if (en) begin
      if (!dir) begin
        do_step = 1'b1;
        new_idx = nxt_q[idx_q];
      end else if (pred_found) begin
        do_step = 1'b1;
        new_idx = pred_idx;
      end
    end

    if (do_step) begin
      idx_d   = new_idx;
      state_d = {{(NSTATES-1){1'b0}}, 1'b1} << new_idx;
      y_d     = ytab_q[new_idx];
      wrap_d  = (new_idx == '0);
    end

    // Step above reads the table before this write lands.
    if (cfg_we) begin
      if (({1'b0, cfg_idx} < NST) && ({1'b0, cfg_next} < NST)) begin
        nxt_d[cfg_idx]  = cfg_next;
        ytab_d[cfg_idx] = cfg_y;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= {{(NSTATES-1){1'b0}}, 1'b1};
      idx_q     <= '0;
      y_q       <= '0;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      fault_q   <= 1'b0;
      for (int i = 0; i < NSTATES; i++) begin
        nxt_q[i]  <= IW'((i + 1) % NSTATES);
        ytab_q[i] <= YW'(i);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      y_q       <= y_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
      fault_q   <= fault_d;
      nxt_q     <= nxt_d;
      ytab_q    <= ytab_d;
    end
  end

  assign state     = state_q;
  assign state_idx = idx_q;
  assign y         = y_q;
  assign wrap      = wrap_q;
  assign cfg_err   = cfg_err_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_onehot_seq_gen.sv
// Directed and random checks of onehot_seq_gen against a table-level model of the sequencer.
module tb_onehot_seq_gen;

  localparam int N  = 7;
  localparam int YW = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset, en, dir, cfg_we;
  logic [IW-1:0] cfg_idx, cfg_next;
  logic [YW-1:0] cfg_y;
  logic [N-1:0]  state;
  logic [IW-1:0] state_idx;
  logic [YW-1:0] y;
  logic          wrap, cfg_err, fault;

  onehot_seq_gen #(.NSTATES(N), .YW(YW)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_next(cfg_next), .cfg_y(cfg_y),
    .state(state), .state_idx(state_idx), .y(y),
    .wrap(wrap), .cfg_err(cfg_err), .fault(fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain table plus current index.
  int m_next [N];
  int m_y    [N];
  int m_cur;
  int e_y, e_wrap, e_err, e_fault;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int rst, input int e, input int d, input int we,
                       input int ci, input int cn, input int cy, input int inj);
    int tgt;
    e_wrap = 0; e_err = 0; e_fault = 0;
    if (rst == 0) begin
      for (int i = 0; i < N; i++) begin
        m_next[i] = (i + 1) % N;
        m_y[i]    = i % (1 << YW);
      end
      m_cur = 0; e_y = 0;
      return;
    end
    if (inj != 0) begin
      m_cur = 0; e_y = m_y[0]; e_fault = 1;
    end else if (e != 0) begin
      tgt = -1;
      if (d == 0) tgt = m_next[m_cur];
      else
        for (int j = 0; j < N; j++)
          if (tgt < 0 && m_next[j] == m_cur) tgt = j;
      if (tgt >= 0) begin
        m_cur = tgt; e_y = m_y[tgt]; e_wrap = (tgt == 0);
      end
    end
    if (we != 0) begin
      if (ci < N && cn < N) begin
        m_next[ci] = cn; m_y[ci] = cy;
      end else e_err = 1;
    end
  endtask

  task automatic cyc(input int rst, input int e, input int d, input int we,
                     input int ci, input int cn, input int cy, input int inj);
    @(negedge clk);
    reset = rst[0]; en = e[0]; dir = d[0]; cfg_we = we[0];
    cfg_idx = ci[IW-1:0]; cfg_next = cn[IW-1:0]; cfg_y = cy[YW-1:0];
    if (inj != 0) begin
      force dut.state_q = 7'b0000101;
      #1 release dut.state_q;
    end
    @(posedge clk);
    model(rst, e, d, we, ci, cn, cy, inj);
    #1;
    chk("state", 64'(state), 64'(1 << m_cur));
    chk("state_idx", 64'(state_idx), 64'(m_cur));
    chk("y", 64'(y), 64'(e_y));
    chk("wrap", 64'(wrap), 64'(e_wrap));
    chk("cfg_err", 64'(cfg_err), 64'(e_err));
    chk("fault", 64'(fault), 64'(e_fault));
  endtask

  int leg_next [N] = '{4, 0, 1, 5, 6, 2, 3};
  int leg_y    [N] = '{1, 0, 0, 1, 1, 0, 0};
  int fwd_seq  [N] = '{4, 6, 3, 5, 2, 1, 0};
  int fwd_y    [N] = '{1, 0, 1, 0, 0, 0, 1};
  int rev_seq  [N] = '{1, 2, 5, 3, 6, 4, 0};

  initial begin
    reset = 0; en = 0; dir = 0; cfg_we = 0; cfg_idx = 0; cfg_next = 0; cfg_y = 0;

    // Reset with a concurrent write: the write must be lost.
    cyc(0, 1, 0, 1, 0, 3, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Legacy table load, then 14 forward steps.
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 1, i, leg_next[i], leg_y[i], 0);
    for (int k = 0; k < 14; k++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      chk("legacy_idx", 64'(state_idx), 64'(fwd_seq[k % N]));
      chk("legacy_y", 64'(y), 64'(fwd_y[k % N]));
      chk("legacy_wrap", 64'(wrap), 64'((k % N) == N - 1));
    end

    // Reverse from state 0.
    for (int k = 0; k < N; k++) begin
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      chk("reverse_idx", 64'(state_idx), 64'(rev_seq[k]));
    end

    // Direction toggle mid-run, then hold.
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) cyc(1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, $urandom_range(0, 1), 0, 0, 0, 0, 0);

    // Walk to index 5, then reset mid-sequence with a concurrent write.
    while (m_cur != 5) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 2, 2, 1, 0);
    for (int k = 0; k < 9; k++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      chk("default_idx", 64'(state_idx), 64'((k + 1) % N));
    end

    // Rejected writes leave the table intact.
    cyc(1, 0, 0, 1, 7, 3, 1, 0);
    cyc(1, 0, 0, 1, 3, 7, 1, 0);
    while (m_cur != 0) cyc(1, 1, 0, 0, 0, 0, 0, 0);

    // Self-loop write on the current entry during a step: old entry wins.
    cyc(1, 1, 0, 1, 0, 0, 3, 0);
    chk("rbw_idx", 64'(state_idx), 64'd1);
    while (m_cur != 0) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      chk("selfloop_wrap", 64'(wrap), 64'd1);
    end

    // No predecessor for state 0: reverse must hold.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 1, i, 1, i, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      chk("nopred_idx", 64'(state_idx), 64'd0);
    end

    // Fault injection and recovery.
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("fault_state", 64'(state), 64'd1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      cyc(($urandom_range(0, 39) == 0) ? 0 : 1, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1), $urandom_range(0, 2) == 0,
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
